mqueue: RTL

Multi-lane circular FIFO with probe access and partial rollback. It accepts up to PUSH_W entries and releases up to POP_W entries per clock. Random-access probe read/write is supported, along with tail rollback that discards the youngest entries. It backs the multi-issue instruction buffers and reorder structures, where flush and mispredict recovery need more than a full clear.

---
 rtl/mqueue.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mqueue.sv
// mqueue: multi-lane circular FIFO with probe read/write access and partial
// tail rollback. Accepts up to PUSH_W entries and releases up to POP_W entries
// per clock.
//
// Optional feature: define MQUEUE_ERRCHK_EN to enable the sticky protocol
// error flag on err_OUT. Without it err_OUT is tied low and no check logic
// is built.
//
// Handshake semantics (push and pop sides alike): the requester states a
// count on pushCnt_IN / popCnt_IN. The request is accepted whole in the cycle
// it is presented if it fits the lane width and the start-of-cycle occupancy
// (free space for push, count for pop); otherwise nothing is accepted and the
// requester must re-present it. Popped data is consumed from data_OUT in the
// same cycle as the accepted pop; pushed data appears on the next cycle.
module mqueue #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int PUSH_W     = 2,
    parameter int POP_W      = 2,
    parameter int INIT_CODE  = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush_IN,
    input  logic [2:0]                   pushCnt_IN,
    input  logic [PUSH_W*DATA_WIDTH-1:0] data_IN,
    input  logic [2:0]                   popCnt_IN,
    output logic [POP_W*DATA_WIDTH-1:0]  data_OUT,
    output logic [POP_W-1:0]             popValid_OUT,
    output logic [ADDR_WIDTH:0]          count_OUT,
    output logic [ADDR_WIDTH:0]          freeCnt_OUT,
    output logic                         emptyFlag_OUT,
    output logic                         fullFlag_OUT,
    output logic [ADDR_WIDTH-1:0]        curHead_OUT,
    output logic [ADDR_WIDTH-1:0]        curTail_OUT,
    input  logic                         rollback_IN,
    input  logic [ADDR_WIDTH:0]          rollbackKeep_IN,
    input  logic [ADDR_WIDTH-1:0]        probeIdx_IN,
    output logic [DATA_WIDTH-1:0]        probeData_OUT,
    input  logic                         probePushReq_IN,
    input  logic [DATA_WIDTH-1:0]        probeData_IN,
    output logic                         err_OUT
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CNTW  = ADDR_WIDTH + 1;
    // Comparison width wide enough for both the 3-bit request counts and the occupancy count.
    localparam int CW    = (CNTW > 3) ? CNTW : 3;

    logic [DATA_WIDTH-1:0] buffer [DEPTH];
    logic [ADDR_WIDTH-1:0] head;
    logic [ADDR_WIDTH-1:0] tail;
    logic [CNTW-1:0]       count;

    logic [CW-1:0]         pushReq;
    logic [CW-1:0]         popReq;
    logic [CW-1:0]         countW;
    logic [CW-1:0]         freeW;
    logic [CW-1:0]         keepW;
    logic [CW-1:0]         pushAcc;
    logic [CW-1:0]         popAcc;
    logic                  pushOk;
    logic                  popOk;
    logic                  rollbackLegal;
    logic                  doPush;
    logic [ADDR_WIDTH-1:0] headNext;
    logic [ADDR_WIDTH-1:0] tailNext;
    logic [CNTW-1:0]       countNext;

    // Acceptance decisions from start-of-cycle occupancy; all-or-nothing per side.
    always_comb begin
        pushReq       = CW'(pushCnt_IN);
        popReq        = CW'(popCnt_IN);
        countW        = CW'(count);
        freeW         = CW'(DEPTH) - countW;
        keepW         = CW'(rollbackKeep_IN);
        pushOk        = (pushReq <= CW'(PUSH_W)) && (pushReq <= freeW);
        popOk         = (popReq <= CW'(POP_W)) && (popReq <= countW);
        pushAcc       = pushOk ? pushReq : '0;
        popAcc        = popOk ? popReq : '0;
        // A rollback must keep at least what is being popped and no more than what exists.
        rollbackLegal = rollback_IN && (popAcc <= keepW) && (keepW <= countW);
        // A legal rollback cancels the push; flush drops it as well.
        doPush        = !flush_IN && !rollbackLegal && (pushAcc != '0);
    end

    // Next pointer/count values for the normal and rollback paths (flush/reset handled in the register).
    always_comb begin
        headNext  = head + ADDR_WIDTH'(popAcc);
        tailNext  = tail + ADDR_WIDTH'(pushAcc);
        countNext = CNTW'(countW + pushAcc - popAcc);
        if (rollbackLegal) begin
            tailNext  = head + ADDR_WIDTH'(keepW);
            countNext = CNTW'(keepW - popAcc);
        end
    end

    // Pointer and occupancy registers: reset > flush > rollback > push/pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= (INIT_CODE == 1) ? CNTW'(DEPTH) : '0;
        end else if (flush_IN) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= headNext;
            tail  <= tailNext;
            count <= countNext;
        end
    end

    // Storage: probe write first, then push lanes so a push to the same index wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                buffer[i] <= (INIT_CODE == 1) ? DATA_WIDTH'(i) : '0;
            end
        end else if (!flush_IN) begin
            if (probePushReq_IN) begin
                buffer[probeIdx_IN] <= probeData_IN;
            end
            if (doPush) begin
                for (int j = 0; j < PUSH_W; j++) begin
                    if (CW'(j) < pushAcc) begin
                        buffer[tail + ADDR_WIDTH'(j)] <= data_IN[j*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

    // Pop lanes read contiguously from head, wrapping through index 0.
    always_comb begin
        data_OUT     = '0;
        popValid_OUT = '0;
        for (int i = 0; i < POP_W; i++) begin
            data_OUT[i*DATA_WIDTH +: DATA_WIDTH] = buffer[head + ADDR_WIDTH'(i)];
            popValid_OUT[i]                      = (count > CNTW'(i));
        end
    end

    assign count_OUT     = count;
    assign freeCnt_OUT   = CNTW'(DEPTH) - count;
    assign emptyFlag_OUT = (count == '0);
    assign fullFlag_OUT  = (count == CNTW'(DEPTH));
    assign curHead_OUT   = head;
    assign curTail_OUT   = tail;
    assign probeData_OUT = buffer[probeIdx_IN];

`ifdef MQUEUE_ERRCHK_EN
    logic errReg;
    logic errHit;

    // Any rejected request, illegal rollback or over-width request is a protocol error.
    always_comb begin
        errHit = ((pushReq != '0) && (pushAcc == '0)) ||
                 ((popReq != '0) && (popAcc == '0)) ||
                 (rollback_IN && !rollbackLegal) ||
                 (pushReq > CW'(PUSH_W)) ||
                 (popReq > CW'(POP_W));
    end

    // Sticky error flag, cleared only by reset or flush.
    always_ff @(posedge clk) begin
        if (reset || flush_IN) begin
            errReg <= 1'b0;
        end else if (errHit) begin
            errReg <= 1'b1;
        end
    end

    assign err_OUT = errReg;
`else
    assign err_OUT = 1'b0;
`endif

endmodule
